// File: rtl/uart_tx_fifo_feeder_if.sv
// uart_tx_fifo_feeder_if: producer write port plus transmit-controller handshake.
// Flush exists only when UART_TX_FIFO_FLUSH_EN is defined.
interface uart_tx_fifo_feeder_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  Wr_En;
    logic [7:0]            Wr_Data;
    logic                  Full;
    logic                  Empty;
    logic [DEPTH_LOG2:0]   Level;
    logic                  Overflow;
    logic                  TX_En_Sig;
    logic [7:0]            TX_Data;
    logic                  TX_Done_Sig;
`ifdef UART_TX_FIFO_FLUSH_EN
    logic                  Flush;
`endif

    modport master (
`ifdef UART_TX_FIFO_FLUSH_EN
        output Flush,
`endif
        output Wr_En, Wr_Data, TX_Done_Sig,
        input  Full, Empty, Level, Overflow, TX_En_Sig, TX_Data
    );

    modport slave (
`ifdef UART_TX_FIFO_FLUSH_EN
        input  Flush,
`endif
        input  Wr_En, Wr_Data, TX_Done_Sig,
        output Full, Empty, Level, Overflow, TX_En_Sig, TX_Data
    );
endinterface

// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder: circular byte FIFO feeding the UART transmit controller on demand.
// Define UART_TX_FIFO_FLUSH_EN to add the Flush input.
module uart_tx_fifo_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 0
) (
    input logic CLK,
    input logic RSTn,
    uart_tx_fifo_feeder_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level_nxt;
    logic [7:0]            gap_cnt;
    logic                  flush, push, pop;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush = bus.Flush;
`else
    assign flush = 1'b0;
`endif

    // a full FIFO rejects writes even when a pop frees a slot on the same edge
    assign push = bus.Wr_En && !bus.Full && !flush;
    assign pop  = state == IDLE && !bus.Empty && !flush;

    always_comb
        level_nxt = flush ? '0 : bus.Level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);

    always_ff @(posedge CLK)
        if (push) mem[wr_ptr] <= bus.Wr_Data;

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.Level    <= '0;
            bus.Full     <= 1'b0;
            bus.Empty    <= 1'b1;
            bus.Overflow <= 1'b0;
        end else begin
            wr_ptr    <= flush ? '0 : wr_ptr + DEPTH_LOG2'(push);
            rd_ptr    <= flush ? '0 : rd_ptr + DEPTH_LOG2'(pop);
            bus.Level <= level_nxt;
            bus.Full  <= level_nxt[DEPTH_LOG2];
            bus.Empty <= level_nxt == '0;
            if (bus.Wr_En && bus.Full && !flush) bus.Overflow <= 1'b1;
        end

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            bus.TX_En_Sig <= 1'b0;
            bus.TX_Data   <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    bus.TX_Data   <= mem[rd_ptr];
                    bus.TX_En_Sig <= 1'b1;
                    state         <= SEND;
                end
                SEND: if (bus.TX_Done_Sig) begin
                    bus.TX_En_Sig <= 1'b0;
                    gap_cnt       <= GAP_CYCLES == 0 ? '0 : 8'(GAP_CYCLES - 1);
                    state         <= GAP_CYCLES == 0 ? IDLE : GAP;
                end
                GAP: if (gap_cnt == '0) state <= IDLE;
                     else gap_cnt <= gap_cnt - 8'd1;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: doc/uart_tx_fifo_feeder.md
Name: uart_tx_fifo_feeder

Overview:
- Byte-buffering, pacing stage directly upstream of the UART transmit controller.
- Accepts bytes from producer logic through a write strobe and stores them in a circular FIFO.
- Presents bytes one at a time on TX_Data/TX_En_Sig, and waits for TX_Done_Sig before launching the next byte.
- Replaces the fixed-interval enable generator with demand-driven transmission.

Parameters:
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 bytes (16).
- GAP_CYCLES, 0, idle CLK cycles inserted after each TX_Done_Sig before the next launch (0..255).

Ports:
- CLK  input  1  system clock; the same clock as the transmit controller.
- RSTn  input  1  asynchronous, active-low reset.
- Wr_En  input  1  write strobe; sampled on each rising CLK edge.
- Wr_Data  input  8  byte to enqueue when Wr_En is high.
- Full  output  1  FIFO holds 2**DEPTH_LOG2 bytes.
- Empty  output  1  FIFO holds 0 bytes.
- Level  output  DEPTH_LOG2+1  current FIFO occupancy.
- Overflow  output  1  sticky flag; set by a write while Full.
- TX_En_Sig  output  1  transmit request to the transmit controller.
- TX_Data  output  8  byte being transmitted; stable while TX_En_Sig is high.
- TX_Done_Sig  input  1  single-cycle completion pulse from the transmit controller, synchronous to CLK.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Read/write pointers and Level = 0, Empty = 1, Full = 0, Overflow = 0.
  - TX_En_Sig = 0, TX_Data = 8'h00, FSM = IDLE, gap counter = 0.
- Reset mid-transmission:
  - TX_En_Sig drops immediately.
  - The in-flight byte and all queued bytes are discarded.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit pointers that wrap modulo depth.
  - Level is computed from a separate DEPTH_LOG2+1 bit counter.
  - Full = (Level == 2**DEPTH_LOG2); Empty = (Level == 0). Both are registered and valid in the same cycle as Level.
- Write:
  - When Wr_En=1 and Full=0: store Wr_Data at the write pointer; increment the write pointer and Level.
  - When Wr_En=1 and Full=1: drop the byte and set Overflow.
  - A write is rejected while Full even if a pop occurs in the same cycle.
  - Overflow clears only on reset.
- Simultaneous write and pop (not Full): Level is unchanged, both pointers advance, and data order is preserved.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If Empty=0: pop the head byte into TX_Data, set TX_En_Sig=1, go to SEND. The pop and the launch happen on the same edge.
  - Otherwise stay in IDLE with TX_En_Sig=0.
- SEND:
  - Hold TX_En_Sig=1 and TX_Data constant.
  - On TX_Done_Sig=1: clear TX_En_Sig. If GAP_CYCLES==0 go to IDLE; otherwise load the gap counter with GAP_CYCLES-1 and go to GAP.
- GAP: decrement the counter each cycle; at 0, go to IDLE. TX_En_Sig stays 0.
- TX_Done_Sig in IDLE or GAP is ignored.
- Latency:
  - A byte written at edge k into an empty FIFO with the FSM in IDLE gives TX_En_Sig=1 after edge k+1.
  - TX_En_Sig is low for at least 1 cycle between bytes (1 + GAP_CYCLES cycles), so the transmit controller always sees a fresh rising enable.
- TX_Data keeps its last value after TX_En_Sig falls; it only changes on a launch.

Optional Feature:
- Macro: UART_TX_FIFO_FLUSH_EN.
- When defined:
  - Adds input port Flush (1 bit).
  - Flush=1 at an edge resets the pointers and Level to 0, and sets Empty=1, Full=0.
  - Any Wr_En in the same cycle is ignored.
  - An in-progress SEND continues until TX_Done_Sig; nothing further is launched.
  - Overflow is not cleared.
- When undefined: no Flush port, and the FIFO empties only by transmission or reset.

Test Plan:
- Reset, then write 8'hA5 at edge k -> Level=1 after k; TX_En_Sig=1 and TX_Data=8'hA5 after k+1; Level=0, Empty=1 after k+1.
- Write 8'h01, 8'h02, 8'h03 back-to-back with GAP_CYCLES=0; pulse TX_Done_Sig 10 cycles after each launch -> bytes launch in order 01, 02, 03; TX_En_Sig is low exactly 1 cycle between bytes.
- GAP_CYCLES=5, two queued bytes, TX_Done_Sig at edge d -> TX_En_Sig low from d; second launch at edge d+6.
- Hold TX_Done_Sig=0, write 18 bytes with depth 16 -> first byte launched; 16 bytes stored; Full=1; 1 byte dropped; Overflow=1 and it stays 1.
- Assert RSTn=0 mid-SEND with Level=4 -> TX_En_Sig=0, Level=0, Empty=1 immediately; after release, TX_Done_Sig pulses produce no launch.
- With UART_TX_FIFO_FLUSH_EN: Level=6, Flush=1 while in SEND -> Level=0; after TX_Done_Sig, no further TX_En_Sig.
